// File: rtl/mod_check_pkg.sv
// Shared types and width helpers for the modulus-check scheduler.
package mod_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Stored remainder width; values 0..divisor-1.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor);
    endfunction

    // Bit counter width; must be able to hold the value width itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_mod_engine.sv
// Bit-serial remainder engine: folds one bit per enabled cycle into r mod DIVISOR.
module serial_mod_engine
    import mod_check_pkg::*;
#(
    parameter int DIVISOR = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            clr,
    input  logic                            bit_en,
    input  logic                            bit_in,
    output logic [rem_width(DIVISOR)-1:0]   rem,
    output logic                            is_zero
);

    localparam int RW = rem_width(DIVISOR);
    localparam int EW = RW + 1;
    localparam logic [EW-1:0] DIV_W = EW'(DIVISOR);

    logic [EW-1:0] doubled;
    logic [EW-1:0] reduced;

    // 2r+b never reaches 2*DIVISOR, so one conditional subtract brings it back in range.
    always_comb begin
        doubled = {rem, bit_in};
        reduced = (doubled >= DIV_W) ? (doubled - DIV_W) : doubled;
    end

    // Remainder register: cleared at the start of each word, stepped once per bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (bit_en) begin
            rem <= reduced[RW-1:0];
        end
    end

    assign is_zero = (rem == '0);

endmodule

// File: rtl/mod_check_scheduler.sv
// Round-robin front end sharing one serial modulus engine among NUM_REQ requesters.
//
//   state | meaning
//   IDLE  | waiting for any req_valid; grants the rotate-priority winner this cycle
//   SHIFT | feeding the captured word MSB-first into the engine, one bit per cycle
//   RESP  | result presented on rsp_*; held until rsp_ready
module mod_check_scheduler
    import mod_check_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]          req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              rsp_valid,
    output logic [id_width(NUM_REQ)-1:0]      rsp_id,
    output logic                              rsp_div,
    output logic [rem_width(DIVISOR)-1:0]     rsp_rem,
    input  logic                              rsp_ready,
    output logic                              busy
);

    localparam int IW = id_width(NUM_REQ);
    localparam int RW = rem_width(DIVISOR);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur_id;
    logic [IW-1:0]   winner;
    logic            found;
    logic            grant_en;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]   count;
    logic [RW-1:0]   eng_rem;
    logic            eng_zero;

    // Rotate-priority scan: indices ptr..NUM_REQ-1 first, then 0..ptr-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i < int'(ptr))) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end

    // Ready is held low during reset even though state already reads IDLE.
    assign grant_en = resetn && (state == IDLE) && found;

    // One-hot accept toward the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_en && (winner == IW'(i));
        end
    end

    serial_mod_engine #(
        .DIVISOR (DIVISOR)
    ) u_engine (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (grant_en),
        .bit_en  (state == SHIFT),
        .bit_in  (shift_reg[WIDTH-1]),
        .rem     (eng_rem),
        .is_zero (eng_zero)
    );

    // Sequencer: capture on grant, shift WIDTH bits, present result, rotate pointer on handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            shift_reg <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        shift_reg <= req_data[int'(winner)*WIDTH +: WIDTH];
                        cur_id    <= winner;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    count     <= count + CW'(1);
                    if (count == LAST_CNT) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_id    <= '0;
                        busy      <= 1'b0;
                        ptr       <= (cur_id == LAST_ID) ? '0 : (cur_id + IW'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Engine holds its final remainder through RESP; outside RESP the result port reads zero.
    assign rsp_div = rsp_valid & eng_zero;
    assign rsp_rem = rsp_valid ? eng_rem : '0;

endmodule

// File: tb/tb_mod_check_scheduler.sv
// Scoreboard bench: a rotate-priority/modulo reference predicts each grant and result;
// separate monitors compare whatever the DUTs present on their response ports.
module tb_mod_check_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 3;

    typedef struct {
        int id;
        int word;
        int gcyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic         rsp_div;
    logic [1:0]   rsp_rem;
    logic         rsp_ready;
    logic         busy;

    logic [0:0]   req_valid2;
    logic [3:0]   req_data2;
    logic [0:0]   req_ready2;
    logic         rsp_valid2;
    logic [0:0]   rsp_id2;
    logic         rsp_div2;
    logic [2:0]   rsp_rem2;
    logic         rsp_ready2;
    logic         busy2;

    logic [N-1:0] pend_valid;
    logic [W-1:0] pend_word [N];

    exp_t q[$];
    int   q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mptr = 0;
    bit   inflight = 1'b0;

    always #5 clk = ~clk;

    assign req_valid = pend_valid;
    assign req_data  = {pend_word[3], pend_word[2], pend_word[1], pend_word[0]};

    mod_check_scheduler #(.NUM_REQ(N), .WIDTH(W), .DIVISOR(D)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_div   (rsp_div),
        .rsp_rem   (rsp_rem),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    mod_check_scheduler #(.NUM_REQ(1), .WIDTH(4), .DIVISOR(5)) dut2 (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid2),
        .req_data  (req_data2),
        .req_ready (req_ready2),
        .rsp_valid (rsp_valid2),
        .rsp_id    (rsp_id2),
        .rsp_div   (rsp_div2),
        .rsp_rem   (rsp_rem2),
        .rsp_ready (rsp_ready2),
        .busy      (busy2)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbiter: first valid requester scanning p, p+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock of reference model: check busy/grant at negedge, retire the granted word after the edge.
    task automatic step();
        int   w;
        exp_t e;
        w = -1;
        @(negedge clk);
        if (resetn) begin
            chk("busy", int'(busy), int'(inflight));
            if (inflight) begin
                chk("grant_while_busy", int'(req_ready), 0);
                if (rsp_valid && rsp_ready) inflight = 1'b0;
            end else begin
                w = pick(pend_valid, mptr);
                chk("grant", int'(req_ready), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    e.id   = w;
                    e.word = int'(pend_word[w]);
                    e.gcyc = cyc;
                    q.push_back(e);
                    mptr     = (w + 1) % N;
                    inflight = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) pend_valid[w] = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q.size() != 0 || inflight || pend_valid != '0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", q.size() + int'(inflight) + $countones(pend_valid), 0);
    endtask

    // Response monitor for the 4-requester instance.
    initial begin : mon
        exp_t e;
        bit   in_rsp;
        in_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_rsp = 1'b0;
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", int'(rsp_valid), 0);
                end else begin
                    e = q[0];
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_rem", int'(rsp_rem), e.word % D);
                    chk("rsp_div", int'(rsp_div), ((e.word % D) == 0) ? 1 : 0);
                    chk("rsp_no_ready", int'(req_ready), 0);
                    if (!in_rsp) chk("latency", cyc - e.gcyc, W + 1);
                    in_rsp = 1'b1;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        in_rsp = 1'b0;
                    end
                end
            end else begin
                chk("idle_outputs", int'({rsp_id, rsp_div, rsp_rem}), 0);
            end
        end
    end

    // Response monitor for the single-requester, mod-5 instance.
    initial begin : mon2
        forever begin
            @(negedge clk);
            if (resetn && rsp_valid2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_rsp2", int'(rsp_valid2), 0);
                end else begin
                    chk("sweep_rem", int'(rsp_rem2), q2[0] % 5);
                    chk("sweep_div", int'(rsp_div2), ((q2[0] % 5) == 0) ? 1 : 0);
                    chk("sweep_id", int'(rsp_id2), 0);
                    chk("sweep_busy", int'(busy2), 1);
                    if (rsp_ready2) void'(q2.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bit got;
        resetn     = 1'b0;
        pend_valid = '1;
        for (int i = 0; i < N; i++) pend_word[i] = 8'd0;
        rsp_ready  = 1'b0;
        req_valid2 = 1'b0;
        req_data2  = 4'd0;
        rsp_ready2 = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_outputs", int'({rsp_id, rsp_div, rsp_rem}), 0);
        chk("reset_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        pend_valid = '0;
        resetn     = 1'b1;
        rsp_ready  = 1'b1;

        // Directed words: 9 (divisible), 200 (rem 2), 0 (divisible).
        pend_word[0] = 8'd9;   pend_valid[0] = 1'b1; drain(40);
        pend_word[2] = 8'd200; pend_valid[2] = 1'b1; drain(40);
        pend_word[1] = 8'd0;   pend_valid[1] = 1'b1; drain(40);

        // Every requester valid continuously: rotation and pointer wrap.
        for (int k = 0; k < 60; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!pend_valid[i]) begin
                    pend_word[i]  = 8'($urandom);
                    pend_valid[i] = 1'b1;
                end
            end
        end
        drain(100);

        // Backpressure: result must hold while another requester waits.
        pend_word[2] = 8'd77; pend_valid[2] = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
            if (inflight && !pend_valid[1]) begin
                pend_word[1]  = 8'd100;
                pend_valid[1] = 1'b1;
            end
        end
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        repeat (5) step();
        rsp_ready = 1'b1;
        drain(60);

        // Reset in the middle of SHIFT: word dropped, pointer back to 0.
        pend_word[3] = 8'hA5; pend_valid[3] = 1'b1;
        n = 0;
        while (!inflight && n < 10) begin
            step();
            n++;
        end
        repeat (3) step();
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", int'(rsp_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_outputs", int'({rsp_id, rsp_div, rsp_rem}), 0);
        chk("rst_mid_ready", int'(req_ready), 0);
        q.delete();
        inflight   = 1'b0;
        mptr       = 0;
        pend_valid = '0;
        step();
        step();
        resetn = 1'b1;
        pend_word[1] = 8'd45; pend_word[3] = 8'd46;
        pend_valid   = 4'b1010;
        drain(60);

        // Randomized traffic with random backpressure and legal valid withdrawal.
        for (int k = 0; k < 400; k++) begin
            step();
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 7))
                            0:       pend_word[i] = 8'd0;
                            1:       pend_word[i] = 8'd255;
                            default: pend_word[i] = 8'($urandom);
                        endcase
                        pend_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend_valid[i] = 1'b0;
                end
            end
        end
        rsp_ready = 1'b1;
        drain(300);

        // Single requester, WIDTH=4, DIVISOR=5: every possible word.
        for (int w = 0; w < 16; w++) begin
            req_data2  = 4'(w);
            req_valid2 = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (req_ready2[0]) begin
                    got = 1'b1;
                    q2.push_back(w);
                end
            end
            chk("sweep_grant", int'(got), 1);
            @(posedge clk);
            #1;
            req_valid2 = 1'b0;
            for (int k = 0; k < 20 && q2.size() != 0; k++) @(negedge clk);
            chk("sweep_drain", q2.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
